// File: rtl/instr_word_encoder.sv
// instr_word_encoder: packs class/subtype plus operand fields into 32-bit
// instruction words, buffers them in a DEPTH-entry FIFO and presents each
// word with an incrementing instruction-memory word address over valid/ready.
// Optional macro ENC_PARITY_EN adds out_par, the stored XOR of out_word.
module instr_word_encoder #(
  parameter int unsigned          DEPTH     = 4,
  parameter int unsigned          ADDR_W    = 10,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_class,
  input  logic [2:0]        in_sub,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_opcode,
  input  logic              in_s,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rm,
  input  logic [3:0]        in_rs,
  input  logic [4:0]        in_shamt,
  input  logic [1:0]        in_shtype,
  input  logic [23:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              enc_err,
  output logic [7:0]        err_cnt
`ifdef ENC_PARITY_EN
  ,
  output logic              out_par
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);

`ifdef ENC_PARITY_EN
  localparam int unsigned EW = 33;
`else
  localparam int unsigned EW = 32;
`endif

  logic [31:0]   enc_word;
  logic          enc_legal;
  logic [EW-1:0] enc_entry;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic [PW:0]   count;
  logic          ready_en;
  logic          full;
  logic          accept;
  logic          push;
  logic          pop;

`ifdef ENC_PARITY_EN
  assign enc_entry = {^enc_word, enc_word};
  assign out_par   = head[32];
`else
  assign enc_entry = enc_word;
`endif

  assign full      = (count == (PW+1)'(DEPTH));
  assign in_ready  = ready_en && !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_legal;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign rd_next   = rd_ptr + PW'(1);
  assign out_word  = head[31:0];

  // Field packing; enc_legal flags the class/subtype combinations that exist
  always_comb begin
    enc_word         = '0;
    enc_legal        = 1'b0;
    enc_word[31:28]  = in_cond;
    case (in_class)
      2'b01: begin
        enc_word[19:16] = in_rn;
        enc_word[15:12] = in_rd;
        enc_legal       = 1'b1;
        case (in_sub)
          3'b001: begin
            enc_word[25]    = 1'b1;
            enc_word[24:21] = in_opcode;
            enc_word[20]    = in_s;
            enc_word[11:0]  = in_imm[11:0];
          end
          3'b010: begin
            enc_word[24:21] = in_opcode;
            enc_word[20]    = in_s;
            enc_word[11:7]  = in_shamt;
            enc_word[6:5]   = in_shtype;
            enc_word[3:0]   = in_rm;
          end
          3'b011: begin
            enc_word[24:21] = in_opcode;
            enc_word[20]    = in_s;
            enc_word[11:8]  = in_rs;
            enc_word[6:5]   = in_shtype;
            enc_word[4]     = 1'b1;
            enc_word[3:0]   = in_rm;
          end
          3'b100: begin
            enc_word[23:21] = in_opcode[2:0];
            enc_word[20]    = in_s;
            enc_word[11:8]  = in_rs;
            enc_word[7:4]   = 4'b0110;
            enc_word[3:0]   = in_rm;
          end
          default: enc_legal = 1'b0;
        endcase
      end
      2'b10: begin
        enc_word[27:26] = 2'b01;
        enc_word[24:21] = in_opcode;
        enc_word[20]    = in_s;
        enc_word[19:16] = in_rn;
        enc_word[15:12] = in_rd;
        enc_legal       = 1'b1;
        case (in_sub)
          3'b001: begin
            enc_word[25]   = 1'b1;
            enc_word[11:0] = in_imm[11:0];
          end
          3'b010: begin
            enc_word[11:7] = in_shamt;
            enc_word[6:5]  = in_shtype;
            enc_word[3:0]  = in_rm;
          end
          default: enc_legal = 1'b0;
        endcase
      end
      2'b11: begin
        enc_word[27:26] = 2'b10;
        enc_word[23:0]  = in_imm;
        enc_legal       = 1'b1;
        case (in_sub)
          3'b001:  enc_word[25:24] = 2'b10;
          3'b010:  enc_word[25:24] = 2'b11;
          default: enc_legal       = 1'b0;
        endcase
      end
      default: enc_legal = 1'b0;
    endcase
  end

  // in_ready is held low during reset and opens on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= enc_entry;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_next;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Registered head: loads the incoming word when it becomes the head,
  // otherwise the entry behind the popped one, so no comb path from in_* to out_word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
    end else if (flush) begin
      head <= '0;
    end else if (count == '0) begin
      if (push) head <= enc_entry;
    end else if (pop) begin
      if (count == (PW+1)'(1)) begin
        if (push) head <= enc_entry;
      end else begin
        head <= mem[rd_next];
      end
    end
  end

  // Word address of the head, advancing once per pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     out_addr <= BASE_ADDR;
    else if (flush) out_addr <= BASE_ADDR;
    else if (pop)   out_addr <= out_addr + ADDR_W'(1);
  end

  // Illegal-request pulse and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_err <= 1'b0;
      err_cnt <= '0;
    end else if (flush) begin
      enc_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      enc_err <= accept && !enc_legal;
      if (accept && !enc_legal && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
